// File: rtl/trng_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : trng_conditioner
//  Description : Ring-oscillator entropy conditioner. Controls the oscillator
//                enable, discards a warm-up interval, resynchronises the raw
//                bit, decimates it, applies von Neumann debiasing and a
//                repetition-count health test, and packs the debiased bits
//                into WIDTH-bit words behind a one-deep valid/ready buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module trng_conditioner #(
  parameter int WIDTH         = 16,
  parameter int SAMPLE_DIV    = 4,
  parameter int WARMUP_CYCLES = 1024,
  parameter int REP_LIMIT     = 32
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             start,
  input  logic             raw_bit,
  output logic             ro_enable,
  output logic [WIDTH-1:0] rand_word,
  output logic             rand_valid,
  input  logic             rand_ready,
  output logic             fault
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int WRM_W = $clog2(WARMUP_CYCLES + 1);
  localparam int RUN_W = $clog2(REP_LIMIT + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WRM_W-1:0] WRM_LAST = WRM_W'(WARMUP_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(REP_LIMIT);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             ro_enable_q, ro_enable_d;
  logic             fault_q, fault_d;
  logic [WRM_W-1:0] warm_q, warm_d;
  logic             sync1_q, sync2_q;
  logic             s_bit;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic             first_q, first_d;
  logic             prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bcnt_q, bcnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;

  logic             strobe, emit, trip, free, load;
  logic [RUN_W-1:0] run_inc;

  assign s_bit = sync2_q;

  // Two-flop resynchroniser for the asynchronous oscillator output
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_bit;
      sync2_q <= sync1_q;
    end
  end

  // Strobe, debias emit and repetition lookahead shared by FSM and datapath
  always_comb begin
    strobe  = (state_q == S_RUN) && (div_q == DIV_LAST);
    run_inc = ((run_q != '0) && (s_bit == prev_q)) ? run_q + RUN_W'(1) : RUN_W'(1);
    trip    = strobe && (run_inc == RUN_TRIP);
    emit    = strobe && phase_q && (first_q != s_bit);
    free    = !valid_q || rand_ready;
    load    = (bcnt_q == BIT_FULL) && free;
  end

  // FSM state register with registered enable and fault outputs
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      warm_q      <= '0;
      ro_enable_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      ro_enable_q <= ro_enable_d;
      fault_q     <= fault_d;
    end
  end

  // FSM next state; start low wins from every state
  always_comb begin
    state_d = state_q;
    warm_d  = '0;
    if (!start) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_WARMUP;
        S_WARMUP: begin
          if (warm_q == WRM_LAST) state_d = S_RUN;
          else                    warm_d  = warm_q + WRM_W'(1);
        end
        S_RUN:    if (trip) state_d = S_FAULT;
        default:  state_d = S_FAULT;
      endcase
    end
  end

  // FSM outputs, computed from the next state so they register on the transition edge
  always_comb begin
    ro_enable_d = (state_d == S_WARMUP) || (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  // Datapath registers: divider, pairing, health test, packer and output buffer
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      first_q <= 1'b0;
      prev_q  <= 1'b0;
      run_q   <= '0;
      shift_q <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      first_q <= first_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  // Datapath next state; everything is cleared outside steady RUN
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    first_d = first_q;
    prev_d  = prev_q;
    run_d   = run_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    if ((state_d != S_RUN) || (state_q != S_RUN)) begin
      div_d   = '0;
      phase_d = 1'b0;
      first_d = 1'b0;
      prev_d  = 1'b0;
      run_d   = '0;
      shift_d = '0;
      bcnt_d  = '0;
      valid_d = 1'b0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      if (strobe) begin
        prev_d  = s_bit;
        run_d   = run_inc;
        phase_d = ~phase_q;
        if (!phase_q) first_d = s_bit;
      end
      if (valid_q && rand_ready) valid_d = 1'b0;
      if (load) begin
        word_d  = shift_q;
        valid_d = 1'b1;
        bcnt_d  = '0;
      end
      // A bit arriving on the load edge starts the next word; a full, blocked
      // shift register drops it instead
      if (emit) begin
        if (load) begin
          shift_d = {shift_q[WIDTH-2:0], first_q};
          bcnt_d  = BIT_W'(1);
        end else if (bcnt_q != BIT_FULL) begin
          shift_d = {shift_q[WIDTH-2:0], first_q};
          bcnt_d  = bcnt_q + BIT_W'(1);
        end
      end
    end
  end

  assign ro_enable  = ro_enable_q;
  assign fault      = fault_q;
  assign rand_word  = word_q;
  assign rand_valid = valid_q;

endmodule
`default_nettype wire
